// File: rtl/deser_pkg.sv
// Shared types for the serial-to-parallel converter.
//   deser_state_t : assembly-stage state (FILL accepts bits, STALL holds a
//                   finished word until the output register frees up).
package deser_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } deser_state_t;

endpackage : deser_pkg

// File: rtl/deser_out_stage.sv
// Single-entry valid/ready holding register for the assembled word.
// Ports:
//   clk_i, srst_i         clock, asynchronous active-high reset
//   load_en_i             capture load_data_i this edge (only when free/draining)
//   load_data_i [W]       payload to capture
//   free_or_draining_o    combinational: slot empty, or emptying on this edge
//   out_data_o  [W]       registered payload, stable while valid and stalled
//   out_val_o             registered valid
//   out_rdy_i             downstream ready
module deser_out_stage #(
  parameter int unsigned W = 21
) (
  input  logic         clk_i,
  input  logic         srst_i,
  input  logic         load_en_i,
  input  logic [W-1:0] load_data_i,
  output logic         free_or_draining_o,
  output logic [W-1:0] out_data_o,
  output logic         out_val_o,
  input  logic         out_rdy_i
);

  logic [W-1:0] data_q;
  logic         val_q;

  // A new word may land on the same edge the current one is consumed.
  assign free_or_draining_o = ~val_q | out_rdy_i;

  // Payload and valid register; payload only changes on a load.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      data_q <= '0;
      val_q  <= 1'b0;
    end else if (load_en_i) begin
      data_q <= load_data_i;
      val_q  <= 1'b1;
    end else if (val_q && out_rdy_i) begin
      val_q  <= 1'b0;
    end
  end

  assign out_data_o = data_q;
  assign out_val_o  = val_q;

endmodule : deser_out_stage

// File: rtl/deser_stream.sv
// Parametrised serial-to-parallel converter with early-terminate (partial
// word plus valid-bit count) and a valid/ready output.
// Ports:
//   clk_i, srst_i          clock, asynchronous active-high reset
//   data_i                 serial bit
//   data_val_i             data_i valid
//   data_last_i            data_i closes the current word (flush)
//   data_rdy_o             input can take a bit (registered)
//   deser_data_o [DATA_W]  assembled word
//   deser_data_mod_o[CNT_W] number of valid bits, 1..DATA_W
//   deser_data_val_o       output word valid
//   deser_data_rdy_i       downstream ready
module deser_stream
  import deser_pkg::*;
#(
  parameter int unsigned  DATA_W    = 16,
  parameter bit           MSB_FIRST = 1'b1,
  localparam int unsigned CNT_W     = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              data_i,
  input  logic              data_val_i,
  input  logic              data_last_i,
  output logic              data_rdy_o,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [CNT_W-1:0]  deser_data_mod_o,
  output logic              deser_data_val_o,
  input  logic              deser_data_rdy_i
);

  localparam int unsigned OUT_W = DATA_W + CNT_W;

  deser_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic              rdy_q;

  logic [CNT_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  mod_next;
  logic [DATA_W-1:0] asm_next;
  logic              accept;
  logic              complete;
  logic              load_en;
  logic              free_or_draining;
  logic [OUT_W-1:0]  load_word;
  logic [OUT_W-1:0]  out_word;

  // Assembly datapath and next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    load_en   = 1'b0;

    bit_idx   = MSB_FIRST ? (CNT_W'(DATA_W - 1) - cnt_q) : cnt_q;
    // Unwritten positions are always 0, so OR-ing the new bit in is enough.
    asm_next  = asm_q | (DATA_W'(data_i) << bit_idx);
    mod_next  = cnt_q + CNT_W'(1);
    accept    = data_val_i & rdy_q;
    complete  = accept & (data_last_i | (cnt_q == CNT_W'(DATA_W - 1)));
    // In STALL cnt_q still indexes the last bit, so mod_next is the held count.
    load_word = {mod_next, asm_q};

    unique case (state_q)
      FILL: begin
        if (complete) begin
          if (free_or_draining) begin
            load_en   = 1'b1;
            load_word = {mod_next, asm_next};
            cnt_d     = '0;
            asm_d     = '0;
          end else begin
            asm_d     = asm_next;
            state_d   = STALL;
          end
        end else if (accept) begin
          asm_d = asm_next;
          cnt_d = mod_next;
        end
      end
      STALL: begin
        if (free_or_draining) begin
          load_en = 1'b1;
          cnt_d   = '0;
          asm_d   = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State, counter, assembly register and registered input-ready.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q <= FILL;
      cnt_q   <= '0;
      asm_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      rdy_q   <= (state_d == FILL);
    end
  end

  assign data_rdy_o = rdy_q;

  deser_out_stage #(
    .W (OUT_W)
  ) u_out (
    .clk_i              (clk_i),
    .srst_i             (srst_i),
    .load_en_i          (load_en),
    .load_data_i        (load_word),
    .free_or_draining_o (free_or_draining),
    .out_data_o         (out_word),
    .out_val_o          (deser_data_val_o),
    .out_rdy_i          (deser_data_rdy_i)
  );

  assign deser_data_mod_o = out_word[OUT_W-1:DATA_W];
  assign deser_data_o     = out_word[DATA_W-1:0];

endmodule : deser_stream

// File: doc/deser_stream.md
Name: deser_stream

Overview:
Parametrised serial-to-parallel converter, successor to the fixed 16-bit deserializer. It assembles DATA_W bits into a word, with bit order selectable. It also accepts an early-terminate flag that emits a partial word with a valid-bit count. The output side uses a valid/ready handshake, so downstream logic can stall it; input backpressure is applied only when both internal stages are full.

Parameters:
DATA_W, 16, output word width in bits; legal range 2..64.
MSB_FIRST, 1, 1: first received bit lands in bit DATA_W-1; 0: first bit lands in bit 0.
CNT_W, $clog2(DATA_W+1), localparam, width of the bit counter and of deser_data_mod_o; not overridable.

Ports:
clk_i  in  1  clock; all logic on rising edge.
srst_i  in  1  reset, asynchronous assert, active-high; synchronous deassert is provided externally.
data_i  in  1  serial data bit.
data_val_i  in  1  data_i valid this cycle.
data_last_i  in  1  qualifies data_i as the final bit of the current word (flush); ignored when data_val_i=0.
data_rdy_o  out  1  input can accept a bit; a bit is taken when data_val_i & data_rdy_o.
deser_data_o  out  DATA_W  assembled word.
deser_data_mod_o  out  CNT_W  number of valid bits in deser_data_o, 1..DATA_W.
deser_data_val_o  out  1  output word valid.
deser_data_rdy_i  in  1  downstream accepts the word when deser_data_val_o & deser_data_rdy_i.

Behaviour:
- Reset values (asynchronous, immediate): deser_data_o=0, deser_data_mod_o=0, deser_data_val_o=0, data_rdy_o=0. The bit counter, assembly register and state return to FILL, holding 0. data_rdy_o rises on the first clock edge after reset deasserts. A partial word in progress is discarded.
- Assembly stage FSM, states FILL and STALL; data_rdy_o=1 only in FILL.
- FILL: each accepted bit is written at index cnt (MSB_FIRST=0) or DATA_W-1-cnt (MSB_FIRST=1), then cnt increments.
- A word completes on the accepting edge of bit number DATA_W, or of any accepted bit with data_last_i=1; mod = cnt+1 at that bit.
- On completion, if the output slot is free or is being drained this cycle, the word and mod load into the output register on the same edge. deser_data_val_o is 1 on the next cycle, a latency of 1 cycle after the last bit. cnt clears to 0 and the assembly register clears, so back-to-back words run at full bit rate.
- On completion with the output slot occupied and not draining, the word and mod are held in the assembly stage and the FSM moves to STALL.
- STALL: data_rdy_o=0 and no bits are accepted. On the edge where the output drains (val & rdy), the held word moves into the output register, the FSM returns to FILL and cnt clears. deser_data_val_o stays 1 continuously across this transfer.
- Unwritten bits of a partial word are 0: the low bits when MSB_FIRST=1, the high bits when MSB_FIRST=0.
- data_last_i on bit DATA_W behaves identically to a plain full word, with mod=DATA_W.
- There is no way to emit an empty word; data_last_i without data_val_i is ignored.
- Output register rules:
  - deser_data_val_o clears on handshake unless a new word loads on the same edge.
  - deser_data_o and deser_data_mod_o are stable while val=1 and rdy=0.
  - If deser_data_rdy_i is permanently 1, the output stage never stalls.
- The count arithmetic is unsigned CNT_W bits; cnt never exceeds DATA_W-1 in FILL.

Decomposition:
- Package deser_pkg: typedef enum logic {FILL, STALL} deser_state_t.
- Sub-module deser_out_stage: a parametrised DATA_W+CNT_W-bit valid/ready holding register. It exposes load_en, a free_or_draining status, and the output handshake. deser_stream instantiates it once and keeps the FSM, counter and assembly register.

Test Plan:
1. DATA_W=16, MSB_FIRST=1, rdy_i=1: stream bits of 16'hA5C3 MSB first, continuously -> one cycle after bit 16, val=1 for 1 cycle, data=16'hA5C3, mod=16. An immediately following word 16'h0001 appears exactly 16 cycles later.
2. DATA_W=16, MSB_FIRST=0: send bits 1,0,1,1 with data_last_i on the 4th -> data=16'h000D, mod=4. Repeat with MSB_FIRST=1 -> data=16'hB000, mod=4.
3. Backpressure, rdy_i=0: send two full words 16'h1234 then 16'h5678 -> word1 held on the output. After bit 32, data_rdy_o=0 and extra bits are not accepted. Raise rdy_i for 1 cycle -> the next cycle shows 16'h5678 with val continuously 1 and data_rdy_o=1.
4. Gapped input, with data_val_i toggling on a random pattern (bits of 16'hFFFF, with gaps) -> output 16'hFFFF, mod=16. data_last_i pulses while data_val_i=0 have no effect.
5. Assert srst_i mid-clock after 7 bits while an output word is pending -> val, data, mod and data_rdy_o go to 0 immediately. The next full word after reset is assembled correctly, and the partial bits are not merged into it.
6. DATA_W=8, MSB_FIRST=0, random 1000 words with random last flags and random rdy_i, checked against a reference model queue -> all words, mods and order match, and no bit is accepted while data_rdy_o=0.
